// File: rtl/mod_arith_pkg.sv
// Shared definitions for the prime-field arithmetic blocks: default field
// constants, the inverse-engine FSM encoding, and helpers that derive the
// Fermat exponent from the modulus.
package mod_arith_pkg;

    localparam int DEF_W   = 9;
    localparam int DEF_P   = 509;
    localparam int ROUND_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EXP  = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    // Number of exponent bits processed for modulus p.
    function automatic int ebits_of(input int p);
        return $clog2(p);
    endfunction

    // Fermat exponent: a^(p-2) is the inverse of a in GF(p).
    function automatic int exp_of(input int p);
        return p - 2;
    endfunction

endpackage

// File: rtl/mod_mult.sv
// Pipelined modular multiplier: out = a*b mod P after exactly MUL_LAT cycles.
// The product and its reduction land in the first stage; later stages only
// delay the result so the latency is a fixed, parameterised number.
module mod_mult
    import mod_arith_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int P       = DEF_P,
    parameter int MUL_LAT = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid_in,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         valid_out,
    output logic [W-1:0] p
);

    localparam logic [2*W-1:0] P_WIDE = (2*W)'(P);

    logic [2*W-1:0] prod;
    logic [W-1:0]   red;
    logic [W-1:0]   pipe_reg [MUL_LAT];
    logic           vld_reg  [MUL_LAT];

    assign prod = (2*W)'(a) * (2*W)'(b);
    assign red  = W'(prod % P_WIDE);

    generate
        for (genvar gi = 0; gi < MUL_LAT; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                // First stage captures the reduced product.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        pipe_reg[gi] <= '0;
                        vld_reg[gi]  <= 1'b0;
                    end else begin
                        pipe_reg[gi] <= red;
                        vld_reg[gi]  <= valid_in;
                    end
                end
            end else begin : g_delay
                // Later stages only delay result and valid together.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        pipe_reg[gi] <= '0;
                        vld_reg[gi]  <= 1'b0;
                    end else begin
                        pipe_reg[gi] <= pipe_reg[gi-1];
                        vld_reg[gi]  <= vld_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign p         = pipe_reg[MUL_LAT-1];
    assign valid_out = vld_reg[MUL_LAT-1];

endmodule

// File: rtl/mod_inv_engine.sv
// Modular inverse over GF(P) by Fermat: a^(P-2) mod P using right-to-left
// square-and-multiply. Each round issues res*base (or res*1 when the exponent
// bit is clear) and base*base on two multipliers in parallel, then waits for
// both results. One job in flight; bypass mode returns the raw operand.
module mod_inv_engine
    import mod_arith_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int P       = DEF_P,
    parameter int MUL_LAT = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               mode,
    input  logic [W-1:0]       data_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W-1:0]       data_out,
    output logic               out_err,
    output logic [ROUND_W-1:0] round_cnt
);

    localparam int             EBITS = ebits_of(P);
    localparam logic [EBITS-1:0] E_VEC = EBITS'(exp_of(P));
    localparam logic [W-1:0]   P_W   = W'(P);
    localparam logic [W-1:0]   ONE   = W'(1);
    localparam int             PH_W  = $clog2(MUL_LAT + 1);
    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(EBITS - 1);

    // A single conditional subtract only fully reduces when P > 2^(W-1).
    generate
        if ((P <= (2 ** (W - 1))) || (P >= (2 ** W))) begin : g_bad_p
            $error("mod_inv_engine: P must satisfy 2^(W-1) < P < 2^W");
        end
        if (MUL_LAT < 1) begin : g_bad_lat
            $error("mod_inv_engine: MUL_LAT must be at least 1");
        end
    endgenerate

    state_t             state_reg;
    logic [W-1:0]       op_reg;
    logic [W-1:0]       res_reg;
    logic [W-1:0]       base_reg;
    logic [W-1:0]       data_out_reg;
    logic               zero_reg;
    logic               out_valid_reg;
    logic               out_err_reg;
    logic               in_ready_reg;
    logic [ROUND_W-1:0] i_reg;
    logic [PH_W-1:0]    phase_reg;

    logic [W-1:0] a_red;
    logic         issue;
    logic [W-1:0] res_mul_b;
    logic [W-1:0] res_prod;
    logic [W-1:0] base_prod;
    logic         res_done;
    logic         base_done;
    logic         mul_done;

    assign a_red     = (data_in >= P_W) ? (data_in - P_W) : data_in;
    assign issue     = (state_reg == ST_EXP) && (phase_reg == '0);
    // Clear exponent bit: multiply by one so res passes through unchanged.
    assign res_mul_b = E_VEC[i_reg] ? base_reg : ONE;
    assign mul_done  = res_done & base_done;

    mod_mult #(.W(W), .P(P), .MUL_LAT(MUL_LAT)) u_res_mult (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (issue),
        .a         (res_reg),
        .b         (res_mul_b),
        .valid_out (res_done),
        .p         (res_prod)
    );

    mod_mult #(.W(W), .P(P), .MUL_LAT(MUL_LAT)) u_base_mult (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (issue),
        .a         (base_reg),
        .b         (base_reg),
        .valid_out (base_done),
        .p         (base_prod)
    );

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            op_reg        <= '0;
            res_reg       <= '0;
            base_reg      <= '0;
            data_out_reg  <= '0;
            zero_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
            out_err_reg   <= 1'b0;
            in_ready_reg  <= 1'b0;
            i_reg         <= '0;
            phase_reg     <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid && in_ready_reg) begin
                        in_ready_reg <= 1'b0;
                        op_reg       <= a_red;
                        if (mode) begin
                            state_reg <= ST_LOAD;
                        end else begin
                            data_out_reg  <= data_in;
                            out_err_reg   <= 1'b0;
                            out_valid_reg <= 1'b1;
                            state_reg     <= ST_OUT;
                        end
                    end else begin
                        in_ready_reg <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    res_reg   <= ONE;
                    base_reg  <= op_reg;
                    zero_reg  <= (op_reg == '0);
                    i_reg     <= '0;
                    phase_reg <= '0;
                    state_reg <= ST_EXP;
                end
                ST_EXP: begin
                    if (mul_done) begin
                        res_reg   <= res_prod;
                        base_reg  <= base_prod;
                        phase_reg <= '0;
                        if (i_reg == LAST_ROUND) begin
                            data_out_reg  <= res_prod;
                            out_err_reg   <= zero_reg;
                            out_valid_reg <= 1'b1;
                            i_reg         <= '0;
                            state_reg     <= ST_OUT;
                        end else begin
                            i_reg <= i_reg + ROUND_W'(1);
                        end
                    end else begin
                        phase_reg <= phase_reg + PH_W'(1);
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        out_err_reg   <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign data_out  = data_out_reg;
    assign out_err   = out_err_reg;
    assign round_cnt = i_reg;

endmodule

// File: tb/tb_mod_inv_engine.sv
// Directed bench for mod_inv_engine: hand-computed inverses over GF(509),
// bypass, zero operands, output backpressure, mid-job reset and a random
// sweep checked by a*result mod 509 == 1.
module tb_mod_inv_engine;

    localparam int W = 9;
    localparam int P = 509;
    localparam int INV_LAT = 29;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         mode = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] data_out;
    logic         out_err;
    logic [3:0]   round_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    mod_inv_engine #(.W(W), .P(P), .MUL_LAT(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .out_err   (out_err),
        .round_cnt (round_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for in_ready, present one operand, wait for the result, drain it.
    task automatic run_job(input logic m, input logic [W-1:0] d,
                           output logic [W-1:0] res, output logic err, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 100) begin tick(); w++; end
        check("in_ready_before_accept", 32'(in_ready), 1);
        in_valid = 1'b1; mode = m; data_in = d;
        tick();
        in_valid = 1'b0; mode = ~m; data_in = W'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin tick(); lat++; end
        check("out_valid_arrived", 32'(out_valid), 1);
        res = data_out;
        err = out_err;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("out_valid_drop", 32'(out_valid), 0);
        check("in_ready_after_xfer", 32'(in_ready), 1);
    endtask

    typedef struct {
        logic         m;
        logic [W-1:0] din;
        logic [W-1:0] exp_out;
        logic         exp_err;
        int           exp_lat;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [W-1:0] res;
        logic         err;
        int           lat;
        int           seen;
        int           w;

        vecs[0] = '{1'b1, 9'd2,    9'd255,  1'b0, INV_LAT};
        vecs[1] = '{1'b1, 9'd3,    9'd170,  1'b0, INV_LAT};
        vecs[2] = '{1'b1, 9'd508,  9'd508,  1'b0, INV_LAT};
        vecs[3] = '{1'b1, 9'd510,  9'd1,    1'b0, INV_LAT};
        vecs[4] = '{1'b1, 9'd1,    9'd1,    1'b0, INV_LAT};
        vecs[5] = '{1'b1, 9'd0,    9'd0,    1'b1, INV_LAT};
        vecs[6] = '{1'b1, 9'd509,  9'd0,    1'b1, INV_LAT};
        vecs[7] = '{1'b0, 9'h1AB,  9'h1AB,  1'b0, 1};
        vecs[8] = '{1'b0, 9'd511,  9'd511,  1'b0, 1};

        // Reset state
        #12;
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_data_out", 32'(data_out), 0);
        check("rst_out_err", 32'(out_err), 0);
        check("rst_round_cnt", 32'(round_cnt), 0);
        tick();
        rst_n = 1'b1;
        check("in_ready_at_release", 32'(in_ready), 0);
        tick();
        check("in_ready_after_release", 32'(in_ready), 1);

        // Directed vectors
        foreach (vecs[k]) begin
            run_job(vecs[k].m, vecs[k].din, res, err, lat);
            $display("job %0d mode=%0d in=%0d out=%0d err=%0d lat=%0d",
                     k, vecs[k].m, vecs[k].din, res, err, lat);
            check($sformatf("data_out_v%0d", k), 32'(res), 32'(vecs[k].exp_out));
            check($sformatf("out_err_v%0d", k), 32'(err), 32'(vecs[k].exp_err));
            check($sformatf("latency_v%0d", k), 32'(lat), 32'(vecs[k].exp_lat));
        end

        // Backpressure: hold result for 5 cycles with a competing in_valid
        w = 0;
        while (!in_ready && w < 100) begin tick(); w++; end
        in_valid = 1'b1; mode = 1'b1; data_in = 9'd3;
        tick();
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 100) begin tick(); w++; end
        check("bp_out_valid", 32'(out_valid), 1);
        check("bp_first_data", 32'(data_out), 170);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; mode = 1'b0; data_in = 9'd7;
            tick();
            check($sformatf("bp_hold_valid_%0d", c), 32'(out_valid), 1);
            check($sformatf("bp_hold_data_%0d", c), 32'(data_out), 170);
            check($sformatf("bp_hold_err_%0d", c), 32'(out_err), 0);
            check($sformatf("bp_in_ready_%0d", c), 32'(in_ready), 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_drop_valid", 32'(out_valid), 0);
        check("bp_in_ready_back", 32'(in_ready), 1);
        seen = 0;
        for (int c = 0; c < 4; c++) begin tick(); if (out_valid) seen++; end
        check("bp_ignored_operand", 32'(seen), 0);
        $display("job backpressure in=3 out=170 held 5 cycles");

        // Reset in round 4 of a job
        w = 0;
        while (!in_ready && w < 100) begin tick(); w++; end
        in_valid = 1'b1; mode = 1'b1; data_in = 9'd2;
        tick();
        in_valid = 1'b0;
        w = 0;
        while (round_cnt != 4'd4 && w < 100) begin tick(); w++; end
        check("reached_round4", 32'(round_cnt), 4);
        #2 rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 0);
        check("abort_in_ready", 32'(in_ready), 0);
        check("abort_round_cnt", 32'(round_cnt), 0);
        check("abort_data_out", 32'(data_out), 0);
        check("abort_out_err", 32'(out_err), 0);
        tick(); tick(); tick();
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 40; c++) begin tick(); if (out_valid) seen++; end
        check("abort_no_result", 32'(seen), 0);
        run_job(1'b1, 9'd2, res, err, lat);
        $display("job after_reset mode=1 in=2 out=%0d err=%0d lat=%0d", res, err, lat);
        check("after_reset_data", 32'(res), 255);
        check("after_reset_lat", 32'(lat), INV_LAT);

        // Random sweep: product with the returned inverse must be 1 mod P
        for (int k = 0; k < 12; k++) begin
            int a;
            a = int'($urandom_range(1, P - 1));
            run_job(1'b1, W'(a), res, err, lat);
            $display("job sweep%0d mode=1 in=%0d out=%0d err=%0d lat=%0d", k, a, res, err, lat);
            check($sformatf("sweep_inv_%0d", a), 32'((a * int'(res)) % P), 1);
            check($sformatf("sweep_err_%0d", a), 32'(err), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
